// File: rtl/rlwe_dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Package : rlwe_dmem_pkg
//  Brief   : Memory-interface enumerations shared by the DMEM responder and its requesters.
//  Rev     : 1.0  initial release
// ============================================================================
package rlwe_dmem_pkg;

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD = 2'd0,
        SCR1_MEM_CMD_WR = 2'd1
    } type_scr1_mem_cmd_e;

    typedef enum logic [2:0] {
        SCR1_MEM_WIDTH_BYTE   = 3'd0,
        SCR1_MEM_WIDTH_HWORD  = 3'd1,
        SCR1_MEM_WIDTH_WORD   = 3'd2,
        SCR1_MEM_WIDTH_VECTOR = 3'd3
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'd0,
        SCR1_MEM_RESP_RDY_OK = 2'd1,
        SCR1_MEM_RESP_RDY_ER = 2'd2
    } type_scr1_mem_resp_e;

endpackage
`default_nettype wire

// File: rtl/rlwe_dmem_vec_resp.sv
`default_nettype none
// ============================================================================
//  Module : rlwe_dmem_vec_resp
//  Brief  : Vector-core DMEM responder; scalar and full-row accesses with a fixed response latency.
//  Rev    : 1.0  initial release
// ============================================================================
module rlwe_dmem_vec_resp
    import rlwe_dmem_pkg::*;
#(
    parameter int          LANE         = 16,
    parameter int          DEPTH_VEC    = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          RESP_LATENCY = 1,
    parameter int          DMEM_AWIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dmem_req,
    input  type_scr1_mem_cmd_e         dmem_cmd,
    input  type_scr1_mem_width_e       dmem_width,
    input  logic [DMEM_AWIDTH-1:0]     dmem_addr,
    input  logic [LANE-1:0][31:0]      dmem_wdata,
    output logic                       dmem_req_ack,
    output logic [LANE-1:0][31:0]      dmem_rdata,
    output type_scr1_mem_resp_e        dmem_resp
);

    localparam int          LB       = $clog2(LANE);
    localparam int          RW       = $clog2(DEPTH_VEC);
    localparam logic [63:0] SPAN     = 64'(DEPTH_VEC) * 64'(LANE) * 64'd4;
    localparam logic [1:0]  CNT_INIT = (RESP_LATENCY > 1) ? 2'(RESP_LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                   state;
    logic [1:0]               lat_cnt;
    type_scr1_mem_cmd_e       cap_cmd;
    type_scr1_mem_width_e     cap_width;
    logic [DMEM_AWIDTH-1:0]   cap_addr;
    logic [LANE-1:0][31:0]    cap_wdata;

    logic [LANE-1:0][31:0]    mem [DEPTH_VEC];

    // In IDLE the live request is decoded so latency 1 can answer on the next cycle.
    type_scr1_mem_cmd_e       sel_cmd;
    type_scr1_mem_width_e     sel_width;
    logic [DMEM_AWIDTH-1:0]   sel_addr;
    logic [DMEM_AWIDTH-1:0]   off;
    logic [RW-1:0]            row;
    logic [LB-1:0]            lane;
    logic [1:0]               byte_sel;
    logic                     err;
    logic [31:0]              word;
    logic [31:0]              shifted;
    logic [LANE-1:0][31:0]    rd_data;
    logic                     wr_en;

    assign dmem_req_ack = (state == S_IDLE);
    assign sel_cmd      = (state == S_IDLE) ? dmem_cmd   : cap_cmd;
    assign sel_width    = (state == S_IDLE) ? dmem_width : cap_width;
    assign sel_addr     = (state == S_IDLE) ? dmem_addr  : cap_addr;

    assign off      = sel_addr - DMEM_AWIDTH'(BASE_ADDR);
    assign row      = RW'(off >> (LB + 2));
    assign lane     = sel_addr[LB+1:2];
    assign byte_sel = sel_addr[1:0];
    assign word     = mem[row][lane];
    assign shifted  = word >> {byte_sel, 3'b000};

    always_comb begin
        err = 1'b0;
        if ((sel_addr < DMEM_AWIDTH'(BASE_ADDR)) || (64'(off) >= SPAN)) begin
            err = 1'b1;
        end
        case (sel_width)
            SCR1_MEM_WIDTH_BYTE:   ;
            SCR1_MEM_WIDTH_HWORD:  if (sel_addr[0])         err = 1'b1;
            SCR1_MEM_WIDTH_WORD:   if (|sel_addr[1:0])      err = 1'b1;
            SCR1_MEM_WIDTH_VECTOR: if (|sel_addr[LB+1:0])   err = 1'b1;
            default:               err = 1'b1;
        endcase
        if ((sel_cmd != SCR1_MEM_CMD_RD) && (sel_cmd != SCR1_MEM_CMD_WR)) begin
            err = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (!err && (sel_cmd == SCR1_MEM_CMD_RD)) begin
            case (sel_width)
                SCR1_MEM_WIDTH_BYTE:   rd_data[0] = {24'h0, shifted[7:0]};
                SCR1_MEM_WIDTH_HWORD:  rd_data[0] = {16'h0, shifted[15:0]};
                SCR1_MEM_WIDTH_WORD:   rd_data[0] = word;
                SCR1_MEM_WIDTH_VECTOR: rd_data    = mem[row];
                default:               rd_data    = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lat_cnt    <= 2'd0;
            dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
            dmem_rdata <= '0;
            cap_cmd    <= SCR1_MEM_CMD_RD;
            cap_width  <= SCR1_MEM_WIDTH_BYTE;
            cap_addr   <= '0;
            cap_wdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dmem_req && dmem_req_ack) begin
                        cap_cmd   <= dmem_cmd;
                        cap_width <= dmem_width;
                        cap_addr  <= dmem_addr;
                        cap_wdata <= dmem_wdata;
                        if (RESP_LATENCY == 1) begin
                            state      <= S_RESP;
                            dmem_resp  <= err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                            dmem_rdata <= rd_data;
                        end else begin
                            state   <= S_WAIT;
                            lat_cnt <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        state      <= S_RESP;
                        dmem_resp  <= err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                        dmem_rdata <= rd_data;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
                    dmem_rdata <= '0;
                end
                default: begin
                    state      <= S_IDLE;
                    dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
                    dmem_rdata <= '0;
                end
            endcase
        end
    end

    // A reset in WAIT clears dmem_resp, so an aborted store never reaches the array.
    assign wr_en = (state == S_RESP) && (dmem_resp == SCR1_MEM_RESP_RDY_OK) &&
                   (cap_cmd == SCR1_MEM_CMD_WR);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (cap_width)
                SCR1_MEM_WIDTH_BYTE:   mem[row][lane][{byte_sel, 3'b000} +: 8]  <= cap_wdata[0][7:0];
                SCR1_MEM_WIDTH_HWORD:  mem[row][lane][{byte_sel, 3'b000} +: 16] <= cap_wdata[0][15:0];
                SCR1_MEM_WIDTH_WORD:   mem[row][lane] <= cap_wdata[0];
                SCR1_MEM_WIDTH_VECTOR: mem[row]       <= cap_wdata;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rlwe_dmem_vec_resp.sv
`default_nettype none
// ============================================================================
//  Module : tb_rlwe_dmem_vec_resp
//  Brief  : Directed scoreboard bench for rlwe_dmem_vec_resp at latency 1 and 3.
//  Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rlwe_dmem_vec_resp;
    import rlwe_dmem_pkg::*;

    typedef logic [15:0][31:0] vec_t;
    typedef struct {
        type_scr1_mem_resp_e resp;
        vec_t                data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 req   [2];
    type_scr1_mem_cmd_e   cmd   [2];
    type_scr1_mem_width_e width [2];
    logic [31:0]          addr  [2];
    vec_t                 wdata [2];
    logic                 ack   [2];
    vec_t                 rdata [2];
    type_scr1_mem_resp_e  resp  [2];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rlwe_dmem_vec_resp #(.LANE(16), .DEPTH_VEC(256), .BASE_ADDR(32'h0), .RESP_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .dmem_req(req[0]), .dmem_cmd(cmd[0]), .dmem_width(width[0]),
        .dmem_addr(addr[0]), .dmem_wdata(wdata[0]), .dmem_req_ack(ack[0]),
        .dmem_rdata(rdata[0]), .dmem_resp(resp[0]));

    rlwe_dmem_vec_resp #(.LANE(16), .DEPTH_VEC(256), .BASE_ADDR(32'h0), .RESP_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .dmem_req(req[1]), .dmem_cmd(cmd[1]), .dmem_width(width[1]),
        .dmem_addr(addr[1]), .dmem_wdata(wdata[1]), .dmem_req_ack(ack[1]),
        .dmem_rdata(rdata[1]), .dmem_resp(resp[1]));

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t w0(input logic [31:0] v);
        vec_t r;
        r    = '0;
        r[0] = v;
        return r;
    endfunction

    task automatic push_exp(input type_scr1_mem_resp_e r, input vec_t d);
        exp_t e;
        e.resp = r;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int w, input string tag);
        exp_t e;
        chk({tag, "_sb"}, 512'(sb.size() != 0), 512'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_resp"}, 512'(resp[w]), 512'(e.resp));
            chk({tag, "_rdata"}, rdata[w], e.data);
        end
    endtask

    // One complete transaction: drive, wait for accept, release req, wait for response.
    task automatic xact(input int w, input string tag, input type_scr1_mem_cmd_e c,
                        input type_scr1_mem_width_e wd, input logic [31:0] a, input vec_t d,
                        input type_scr1_mem_resp_e er, input vec_t ed, input int lat);
        int n;
        bit got;
        push_exp(er, ed);
        req[w] = 1'b1; cmd[w] = c; width[w] = wd; addr[w] = a; wdata[w] = d;
        n = 0; got = 1'b0;
        while (n < 10 && !got) begin
            @(negedge clk);
            if (ack[w] === 1'b1) got = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        chk({tag, "_accept"}, 512'(got), 512'd1);
        @(posedge clk); #1;
        req[w] = 1'b0;
        n = 0; got = 1'b0;
        while (n < 10 && !got) begin
            @(negedge clk);
            n++;
            if (resp[w] !== SCR1_MEM_RESP_NOTRDY) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk({tag, "_latency"}, 512'(got ? n : -1), 512'(lat));
        if (got) begin
            pop_cmp(w, tag);
            @(posedge clk); #1;
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; cmd[i] = SCR1_MEM_CMD_RD; width[i] = SCR1_MEM_WIDTH_WORD;
            addr[i] = '0; wdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ack%0d", i), 512'(ack[i]), 512'd1);
            chk($sformatf("rst_resp%0d", i), 512'(resp[i]), 512'(SCR1_MEM_RESP_NOTRDY));
            chk($sformatf("rst_rdata%0d", i), rdata[i], 512'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store/load
        xact(0, "t1_wr", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h8, w0(32'hDEADBEEF), SCR1_MEM_RESP_RDY_OK, '0, 1);
        xact(0, "t1_rd", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h8, '0, SCR1_MEM_RESP_RDY_OK, w0(32'hDEADBEEF), 1);

        // Byte merge and sub-word loads
        xact(0, "t2_wr", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h8, w0(32'h11223344), SCR1_MEM_RESP_RDY_OK, '0, 1);
        xact(0, "t2_wb", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h9, w0(32'hFFFFFFA5), SCR1_MEM_RESP_RDY_OK, '0, 1);
        xact(0, "t2_rh", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h8, '0, SCR1_MEM_RESP_RDY_OK, w0(32'h0000A544), 1);
        xact(0, "t2_rh2", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'hA, '0, SCR1_MEM_RESP_RDY_OK, w0(32'h00001122), 1);
        xact(0, "t2_rb", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'hB, '0, SCR1_MEM_RESP_RDY_OK, w0(32'h00000011), 1);

        // Full-row vector access
        for (int i = 0; i < 16; i++) v[i] = 32'(i) * 32'h01010101;
        xact(0, "t3_wv", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'h40, v, SCR1_MEM_RESP_RDY_OK, '0, 1);
        xact(0, "t3_rv", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h40, '0, SCR1_MEM_RESP_RDY_OK, v, 1);

        // Error cases and last legal byte
        xact(0, "t4_mis_w", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h2, '0, SCR1_MEM_RESP_RDY_ER, '0, 1);
        xact(0, "t4_mis_v", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h44, '0, SCR1_MEM_RESP_RDY_ER, '0, 1);
        xact(0, "t4_mis_h", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h41, '0, SCR1_MEM_RESP_RDY_ER, '0, 1);
        xact(0, "t4_oor", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h4000, '0, SCR1_MEM_RESP_RDY_ER, '0, 1);
        xact(0, "t4_bad_w", SCR1_MEM_CMD_RD, type_scr1_mem_width_e'(3'd5), 32'h8, '0, SCR1_MEM_RESP_RDY_ER, '0, 1);
        xact(0, "t4_bad_c", type_scr1_mem_cmd_e'(2'd2), SCR1_MEM_WIDTH_WORD, 32'h8, w0(32'h0), SCR1_MEM_RESP_RDY_ER, '0, 1);
        xact(0, "t4_wr_mis", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'hA, w0(32'hFFFFFFFF), SCR1_MEM_RESP_RDY_ER, '0, 1);
        xact(0, "t4_wr_oor", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h4008, w0(32'hFFFFFFFF), SCR1_MEM_RESP_RDY_ER, '0, 1);
        xact(0, "t4_keep", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h8, '0, SCR1_MEM_RESP_RDY_OK, w0(32'h1122A544), 1);
        xact(0, "t4_top_w", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h3FFF, w0(32'h00000077), SCR1_MEM_RESP_RDY_OK, '0, 1);
        xact(0, "t4_top_r", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h3FFF, '0, SCR1_MEM_RESP_RDY_OK, w0(32'h00000077), 1);
        xact(0, "t4_top_1", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h4000, '0, SCR1_MEM_RESP_RDY_ER, '0, 1);

        // Latency 3 with req held high across two transactions
        req[1] = 1'b1; cmd[1] = SCR1_MEM_CMD_WR; width[1] = SCR1_MEM_WIDTH_WORD;
        addr[1] = 32'h10; wdata[1] = w0(32'hCAFEF00D);
        push_exp(SCR1_MEM_RESP_RDY_OK, '0);
        @(negedge clk);
        chk("t5_ack_c0", 512'(ack[1]), 512'd1);
        @(posedge clk); #1;
        cmd[1] = SCR1_MEM_CMD_RD; wdata[1] = '0;
        push_exp(SCR1_MEM_RESP_RDY_OK, w0(32'hCAFEF00D));
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("t5_ack_c%0d", c), 512'(ack[1]), 512'd0);
            if (c < 3) chk($sformatf("t5_idle_c%0d", c), 512'(resp[1]), 512'(SCR1_MEM_RESP_NOTRDY));
            else       pop_cmp(1, "t5_wr");
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t5_ack_c4", 512'(ack[1]), 512'd1);
        chk("t5_resp_c4", 512'(resp[1]), 512'(SCR1_MEM_RESP_NOTRDY));
        @(posedge clk); #1;
        req[1] = 1'b0;
        for (int c = 5; c <= 7; c++) begin
            @(negedge clk);
            if (c < 7) chk($sformatf("t5_idle_c%0d", c), 512'(resp[1]), 512'(SCR1_MEM_RESP_NOTRDY));
            else       pop_cmp(1, "t5_rd");
            @(posedge clk); #1;
        end

        // Reset during WAIT discards the pending store
        req[1] = 1'b1; cmd[1] = SCR1_MEM_CMD_WR; width[1] = SCR1_MEM_WIDTH_WORD;
        addr[1] = 32'h10; wdata[1] = w0(32'h12345678);
        @(negedge clk);
        chk("t6_accept", 512'(ack[1]), 512'd1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("t6_resp%0d", c), 512'(resp[1]), 512'(SCR1_MEM_RESP_NOTRDY));
            chk($sformatf("t6_ack%0d", c), 512'(ack[1]), 512'd1);
            @(posedge clk); #1;
        end
        xact(1, "t6_rd", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, '0, SCR1_MEM_RESP_RDY_OK, w0(32'hCAFEF00D), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
